// File: rtl/pb_mode_pkg.sv
// Shared types and helpers for the push-button mode controller.
// No logic of its own; the decode function is purely combinational.
// No flow control here.
package pb_mode_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    COMMIT_S,
    COMMIT_L,
    WAIT_REL
  } pb_state_t;

  // Setting applied at reset and by every long press.
  localparam logic [1:0] SETTING_DFLT = 2'b10;

  // Gain scale presented alongside each setting.
  function automatic logic [2:0] setting2scale(input logic [1:0] s);
    logic [2:0] r;
    case (s)
      2'b11:   r = 3'b111;
      2'b10:   r = 3'b101;
      2'b01:   r = 3'b011;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Two-flop synchronizer plus stability counter for a raw push-button level.
// Latency: 2 sync cycles + DB_CYC stable cycles before btn_db follows the pin.
// No backpressure; free-running sampler.
module pb_debounce #(
  parameter int DB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic          sync1;
  logic          sync;
  logic [CW-1:0] db_cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync  <= sync1;
    end
  end

  // Follow sync only after it has disagreed with btn_db for DB_CYC cycles in a row;
  // any agreeing cycle restarts the count so short glitches never get through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (sync != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/pb_mode_ctrl.sv
// Sensitivity-mode controller: short press steps setting, long press restores default.
// Latency: setting/cfg_vld registered one edge after the press is classified.
// cfg_vld holds with setting frozen until cfg_rdy; presses meanwhile are ignored.
module pb_mode_ctrl #(
  parameter int DB_CYC   = 16,
  parameter int LONG_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgglMd,
  input  logic       cfg_rdy,
  output logic [1:0] setting,
  output logic [2:0] scale,
  output logic       cfg_vld,
  output logic       long_evt
);

  import pb_mode_pkg::*;

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);

  logic          btn_db;
  pb_state_t     state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    setting_nxt;
  logic          vld_nxt;
  logic          long_nxt;

  pb_debounce #(.DB_CYC(DB_CYC)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (tgglMd),
    .btn_db  (btn_db)
  );

  // State, hold counter and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      setting  <= SETTING_DFLT;
      cfg_vld  <= 1'b0;
      long_evt <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      setting  <= setting_nxt;
      cfg_vld  <= vld_nxt;
      long_evt <= long_nxt;
    end
  end

  // Classify presses and sequence the configuration handshake.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    setting_nxt = setting;
    vld_nxt     = cfg_vld;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_nxt = PRESS;
          hold_nxt  = '0;
        end
      end
      PRESS: begin
        if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + HW'(1);
        if (btn_db && hold_cnt == HOLD_LONG) begin
          // Long press fires while still held and always re-applies the default.
          setting_nxt = SETTING_DFLT;
          vld_nxt     = 1'b1;
          long_nxt    = 1'b1;
          state_nxt   = COMMIT_L;
        end else if (!btn_db) begin
          if (hold_cnt < HOLD_LONG) begin
            setting_nxt = setting + 2'd1;
            vld_nxt     = 1'b1;
            state_nxt   = COMMIT_S;
          end else begin
            // Release on the exact long-press threshold cycle is neither short
            // nor long; drop it rather than guess.
            state_nxt = IDLE;
          end
        end
      end
      COMMIT_S: begin
        if (cfg_rdy) begin
          vld_nxt   = 1'b0;
          state_nxt = btn_db ? WAIT_REL : IDLE;
        end
      end
      COMMIT_L: begin
        if (cfg_rdy) begin
          vld_nxt   = 1'b0;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!btn_db) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign scale = setting2scale(setting);

endmodule
